// File: rtl/muntjac_btb_train_ctrl.sv
// BTB train-port sequencer: arbitrates resolve/decode training writes through a
// small deduplicating queue and runs the invalidate-all sweep over every BTB index.

package muntjac_btb_train_pkg;

    typedef enum logic [2:0] {
        BRANCH_NONE    = 3'd0,
        BRANCH_JUMP    = 3'd1,
        BRANCH_CALL    = 3'd2,
        BRANCH_RET     = 3'd3,
        BRANCH_YIELD   = 3'd4,
        BRANCH_UNTAKEN = 3'd5,
        BRANCH_TAKEN   = 3'd6
    } branch_type_e;

endpackage

module muntjac_btb_train_ctrl
    import muntjac_btb_train_pkg::*;
#(
    parameter int unsigned AddrLen     = 64,
    parameter int unsigned IndexWidth  = 8,
    parameter int unsigned QueueDepth  = 4,
    parameter int unsigned StarveLimit = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btb_ready_i,

    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  branch_type_e       res_branch_type_i,
    input  logic [AddrLen-1:0] res_pc_i,
    input  logic               res_partial_i,
    input  logic [AddrLen-1:0] res_npc_i,

    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  branch_type_e       dec_branch_type_i,
    input  logic [AddrLen-1:0] dec_pc_i,
    input  logic               dec_partial_i,
    input  logic [AddrLen-1:0] dec_npc_i,

    input  logic               flush_req_i,
    output logic               flush_busy_o,

    output logic               train_valid_o,
    output branch_type_e       train_branch_type_o,
    output logic [AddrLen-1:0] train_pc_o,
    output logic               train_partial_o,
    output logic [AddrLen-1:0] train_npc_o
);

    localparam int unsigned QPtrW = $clog2(QueueDepth);
    localparam int unsigned CntW  = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] { ST_IDLE, ST_DRAIN, ST_SWEEP } state_e;
    typedef logic [QPtrW:0]        ptr_t;
    typedef logic [QPtrW-1:0]      qidx_t;
    typedef logic [CntW-1:0]       cnt_t;
    typedef logic [IndexWidth-1:0] idx_t;

    typedef struct packed {
        branch_type_e       branch_type;
        logic [AddrLen-1:0] pc;
        logic               partial;
        logic [AddrLen-1:0] npc;
    } entry_t;

    localparam cnt_t StarveMax = cnt_t'(StarveLimit);

    state_e state_q, state_d;
    ptr_t   wptr_q, wptr_d, rptr_q, rptr_d;
    cnt_t   starve_q, starve_d;
    idx_t   index_q, index_d;
    entry_t queue_q [QueueDepth];

    logic   q_empty, q_full, can_accept, dec_win, res_grant, dec_grant, dup, enq, issue;
    qidx_t  newest_idx;
    entry_t req, head, newest;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign q_empty    = (wptr_q == rptr_q);
    assign q_full     = (wptr_q[QPtrW] != rptr_q[QPtrW]) &&
                        (wptr_q[QPtrW-1:0] == rptr_q[QPtrW-1:0]);
    assign newest_idx = wptr_q[QPtrW-1:0] - qidx_t'(1);
    assign head       = queue_q[rptr_q[QPtrW-1:0]];
    assign newest     = queue_q[newest_idx];

    assign can_accept  = (state_q == ST_IDLE) && !q_full;
    assign dec_win     = dec_valid_i && (!res_valid_i || (starve_q == StarveMax));
    assign dec_grant   = can_accept && dec_win;
    assign res_grant   = can_accept && res_valid_i && !dec_win;
    assign res_ready_o = res_grant;
    assign dec_ready_o = dec_grant;

    always_comb begin
        req.branch_type = res_branch_type_i;
        req.pc          = res_pc_i;
        req.partial     = res_partial_i;
        req.npc         = res_npc_i;
        if (dec_win) begin
            req.branch_type = dec_branch_type_i;
            req.pc          = dec_pc_i;
            req.partial     = dec_partial_i;
            req.npc         = dec_npc_i;
        end
    end

    assign dup = !q_empty && (req == newest);
    assign enq = (res_grant || dec_grant) && !dup;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (flush_req_i) state_d = ST_DRAIN;
            ST_DRAIN: if (q_empty) state_d = ST_SWEEP;
            ST_SWEEP: if (btb_ready_i && (&index_q)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        issue               = 1'b0;
        train_branch_type_o = BRANCH_NONE;
        train_pc_o          = '0;
        train_partial_o     = 1'b0;
        train_npc_o         = '0;
        unique case (state_q)
            ST_SWEEP: begin
                issue      = btb_ready_i;
                train_pc_o = {{(AddrLen-IndexWidth-2){1'b1}}, index_q, 2'b00};
            end
            default: begin
                issue = !q_empty && btb_ready_i;
                if (!q_empty) begin
                    train_branch_type_o = head.branch_type;
                    train_pc_o          = head.pc;
                    train_partial_o     = head.partial;
                    train_npc_o         = head.npc;
                end
            end
        endcase
        train_valid_o = issue;
    end

    assign flush_busy_o = (state_q != ST_IDLE);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        starve_d = starve_q;
        index_d  = '0;
        if (enq) wptr_d = wptr_q + ptr_t'(1);
        if (issue && (state_q != ST_SWEEP)) rptr_d = rptr_q + ptr_t'(1);
        if (state_q == ST_SWEEP) index_d = issue ? index_q + idx_t'(1) : index_q;
        if (dec_grant) begin
            starve_d = '0;
        end else if (dec_valid_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + cnt_t'(1);
        end
    end

    // NOTE: control state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            starve_q <= '0;
            index_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            starve_q <= starve_d;
            index_q  <= index_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers define which entries are live
    // and the outputs are forced to zero while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (enq) queue_q[wptr_q[QPtrW-1:0]] <= req;
    end

endmodule

// File: tb/tb_muntjac_btb_train_ctrl.sv
// Scoreboard bench for muntjac_btb_train_ctrl: directed test-plan scenarios followed
// by randomized traffic, checked against a queue-level reference model.

module tb_muntjac_btb_train_ctrl;
    import muntjac_btb_train_pkg::*;

    localparam int AW     = 64;
    localparam int IW     = 4;
    localparam int QD     = 4;
    localparam int SL     = 4;
    localparam int SweepN = 1 << IW;

    typedef struct packed {
        logic [2:0]    bt;
        logic [AW-1:0] pc;
        logic          partial;
        logic [AW-1:0] npc;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          btb_ready_i = 1'b0;
    logic          res_valid_i = 1'b0, dec_valid_i = 1'b0, flush_req_i = 1'b0;
    branch_type_e  res_branch_type_i = BRANCH_NONE, dec_branch_type_i = BRANCH_NONE;
    logic [AW-1:0] res_pc_i = '0, res_npc_i = '0, dec_pc_i = '0, dec_npc_i = '0;
    logic          res_partial_i = 1'b0, dec_partial_i = 1'b0;
    logic          res_ready_o, dec_ready_o, flush_busy_o, train_valid_o, train_partial_o;
    branch_type_e  train_branch_type_o;
    logic [AW-1:0] train_pc_o, train_npc_o;

    int   tests = 0;
    int   fails = 0;
    ent_t exp_q[$];
    ent_t mq[$];
    int   m_phase = 0;
    int   m_idx   = 0;
    int   m_loss  = 0;

    muntjac_btb_train_ctrl #(
        .AddrLen(AW), .IndexWidth(IW), .QueueDepth(QD), .StarveLimit(SL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .btb_ready_i(btb_ready_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_branch_type_i(res_branch_type_i), .res_pc_i(res_pc_i),
        .res_partial_i(res_partial_i), .res_npc_i(res_npc_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_branch_type_i(dec_branch_type_i), .dec_pc_i(dec_pc_i),
        .dec_partial_i(dec_partial_i), .dec_npc_i(dec_npc_i),
        .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o),
        .train_valid_o(train_valid_o), .train_branch_type_o(train_branch_type_o),
        .train_pc_o(train_pc_o), .train_partial_o(train_partial_o), .train_npc_o(train_npc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t sweep_ent(input int i);
        ent_t e;
        e.bt      = 3'd0;
        e.pc      = 64'hFFFF_FFFF_FFFF_FFC0 | (64'(i) << 2);
        e.partial = 1'b0;
        e.npc     = '0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_res(input bit v, input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                           input int bt, input bit p);
        res_valid_i = v; res_pc_i = pc; res_npc_i = npc;
        res_branch_type_i = branch_type_e'(bt); res_partial_i = p;
    endtask

    task automatic set_dec(input bit v, input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                           input int bt, input bit p);
        dec_valid_i = v; dec_pc_i = pc; dec_npc_i = npc;
        dec_branch_type_i = branch_type_e'(bt); dec_partial_i = p;
    endtask

    // Reference model: phase 0 idle, 1 drain, 2 sweep; mq mirrors queued entries.
    initial begin : model
        ent_t r;
        bit   acc_r, acc_d;
        int   occ;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                mq.delete(); exp_q.delete();
                m_phase = 0; m_idx = 0; m_loss = 0;
            end else begin
                occ   = mq.size();
                acc_r = 1'b0;
                acc_d = 1'b0;
                if (m_phase == 0 && occ < QD) begin
                    if (dec_valid_i && (!res_valid_i || m_loss >= SL)) acc_d = 1'b1;
                    else if (res_valid_i) acc_r = 1'b1;
                end
                check("res_ready", res_ready_o, acc_r);
                check("dec_ready", dec_ready_o, acc_d);
                check("flush_busy", flush_busy_o, m_phase != 0);
                check("train_valid", train_valid_o,
                      (m_phase == 2) ? btb_ready_i : (occ > 0 && btb_ready_i));
                if (acc_r || acc_d) begin
                    r = acc_d ? {dec_branch_type_i, dec_pc_i, dec_partial_i, dec_npc_i}
                              : {res_branch_type_i, res_pc_i, res_partial_i, res_npc_i};
                    if (!(occ > 0 && mq[occ-1] == r)) begin
                        mq.push_back(r);
                        exp_q.push_back(r);
                    end
                end
                if (m_phase != 2 && occ > 0 && btb_ready_i) void'(mq.pop_front());
                if (acc_d) m_loss = 0;
                else if (dec_valid_i && m_loss < SL) m_loss++;
                case (m_phase)
                    0: if (flush_req_i) m_phase = 1;
                    1: if (occ == 0) begin
                        m_phase = 2;
                        m_idx   = 0;
                        for (int i = 0; i < SweepN; i++) exp_q.push_back(sweep_ent(i));
                    end
                    2: if (btb_ready_i) begin
                        m_idx++;
                        if (m_idx == SweepN) m_phase = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin : monitor
        ent_t got;
        forever begin
            @(negedge clk_i);
            if (!rst_i && train_valid_o === 1'b1) begin
                got = {train_branch_type_o, train_pc_o, train_partial_o, train_npc_o};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %0h, no write expected", got);
                end else begin
                    check("train_write", got, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int c;
        #3;
        check("reset_outputs", {train_valid_o, train_branch_type_o, train_pc_o, train_partial_o,
                                train_npc_o, res_ready_o, dec_ready_o, flush_busy_o}, '0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single resolve request, visible the cycle after acceptance.
        btb_ready_i = 1'b1;
        set_res(1'b1, 64'h1000, 64'h2000, 1, 1'b0);
        #1 check("single_accept", res_ready_o, 1'b1);
        step();
        res_valid_i = 1'b0;
        #1 check("single_issue", {train_valid_o, train_pc_o, train_npc_o}, {1'b1, 64'h1000, 64'h2000});
        step();
        #1 check("single_queue_empty", train_valid_o, 1'b0);
        step();

        // Both ports valid: R,R,R,R,D repeating.
        for (int i = 0; i < 10; i++) begin
            set_res(1'b1, 64'h3000 + 64'(i * 4), 64'h3800, 2, 1'b0);
            set_dec(1'b1, 64'h8000 + 64'(i * 4), 64'h8800, 1, 1'b1);
            #1 check("grant_dec", dec_ready_o, (i % 5) == 4);
            check("grant_res", res_ready_o, (i % 5) != 4);
            step();
        end
        res_valid_i = 1'b0;
        dec_valid_i = 1'b0;
        repeat (3) step();

        // Fill the queue while the BTB is stalled; the fifth request must wait.
        btb_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_res(1'b1, 64'h4000 + 64'(k * 16), 64'h5000 + 64'(k * 16), 2, k[0]);
            #1 check("fill_ready", res_ready_o, k < 4);
            step();
        end
        btb_ready_i = 1'b1;
        #1 check("full_no_accept", res_ready_o, 1'b0);
        step();
        #1 check("accept_after_deq", res_ready_o, 1'b1);
        step();
        res_valid_i = 1'b0;
        repeat (6) step();

        // Identical back-to-back requests collapse into one write.
        btb_ready_i = 1'b0;
        set_res(1'b1, 64'h6000, 64'h7000, 3, 1'b1);
        #1 check("dup_first", res_ready_o, 1'b1);
        step();
        #1 check("dup_second", res_ready_o, 1'b1);
        step();
        res_valid_i = 1'b0;
        btb_ready_i = 1'b1;
        #1 check("dup_write", train_valid_o, 1'b1);
        step();
        #1 check("dup_single_write", train_valid_o, 1'b0);
        step();

        // Flush with two queued entries, one accepted in the flush cycle.
        btb_ready_i = 1'b0;
        set_res(1'b1, 64'hA000, 64'hB000, 4, 1'b0);
        step();
        set_res(1'b1, 64'hA100, 64'hB100, 5, 1'b1);
        flush_req_i = 1'b1;
        #1 check("flush_accept", res_ready_o, 1'b1);
        step();
        flush_req_i = 1'b0;
        set_res(1'b1, 64'hC000, 64'hD000, 1, 1'b0);
        btb_ready_i = 1'b1;
        #1 check("drain_busy", flush_busy_o, 1'b1);
        check("drain_no_ready", res_ready_o, 1'b0);
        step();
        c = 0;
        while (flush_busy_o && c < 60) begin
            btb_ready_i = !(c >= 10 && c < 13);
            set_res(1'b1, 64'h100 * 64'($urandom_range(1, 8)), 64'h40, 1, 1'b0);
            set_dec(1'b1, 64'h200 * 64'($urandom_range(1, 8)), 64'h80, 2, 1'b1);
            step();
            c++;
        end
        check("flush_done_in_time", flush_busy_o, 1'b0);
        res_valid_i = 1'b0;
        dec_valid_i = 1'b0;
        repeat (4) step();

        // Asynchronous reset in the middle of a sweep.
        flush_req_i = 1'b1;
        step();
        flush_req_i = 1'b0;
        repeat (5) step();
        #1 check("busy_before_reset", flush_busy_o, 1'b1);
        rst_i = 1'b1;
        #1 check("reset_mid_sweep", {train_valid_o, train_branch_type_o, train_pc_o, train_partial_o,
                                     train_npc_o, res_ready_o, dec_ready_o, flush_busy_o}, '0);
        step();
        rst_i = 1'b0;
        set_res(1'b1, 64'hE000, 64'hF000, 2, 1'b0);
        #1 check("post_reset_idle", flush_busy_o, 1'b0);
        check("post_reset_accept", res_ready_o, 1'b1);
        step();
        res_valid_i = 1'b0;
        repeat (3) step();

        // Randomized traffic over a small value pool so dedup and full cases recur.
        for (int n = 0; n < 400; n++) begin
            btb_ready_i = ($urandom_range(0, 3) != 0);
            set_res($urandom_range(0, 1) == 1, 64'h100 * 64'($urandom_range(1, 2)),
                    64'h40 * 64'($urandom_range(1, 2)), int'($urandom_range(0, 1)),
                    $urandom_range(0, 1) == 1);
            set_dec($urandom_range(0, 1) == 1, 64'h100 * 64'($urandom_range(1, 2)),
                    64'h40 * 64'($urandom_range(1, 2)), int'($urandom_range(0, 1)),
                    $urandom_range(0, 1) == 1);
            flush_req_i = ($urandom_range(0, 49) == 0);
            step();
        end

        res_valid_i = 1'b0;
        dec_valid_i = 1'b0;
        flush_req_i = 1'b0;
        btb_ready_i = 1'b1;
        c = 0;
        while ((flush_busy_o || exp_q.size() != 0) && c < 100) begin
            step();
            c++;
        end
        check("final_idle", flush_busy_o, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
